// File: rtl/zstd_axi_arb_pkg.sv
// rtl/zstd_axi_arb_pkg.sv - AXI field widths and elaboration helpers for the read arbiter
package zstd_axi_arb_pkg;
   localparam int LEN_W   = 8;
   localparam int SIZE_W  = 3;
   localparam int BURST_W = 2;
   localparam int RESP_W  = 3;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < value) r = r + 1;
      end
      return r;
   endfunction
endpackage

// File: rtl/zstd_axi_rd_arbiter_if.sv
// rtl/zstd_axi_rd_arbiter_if.sv - requester-side and memory-side AR/R signals of the read arbiter
interface zstd_axi_rd_arbiter_if
   import zstd_axi_arb_pkg::*;
#(
   parameter int N_MASTERS  = 2,
   parameter int AXI_DATA_W = 32,
   parameter int AXI_ADDR_W = 32,
   parameter int S_AXI_ID_W = 4,
   parameter int M_AXI_ID_W = 6
);
   logic [N_MASTERS*S_AXI_ID_W-1:0] s_ar_arid;
   logic [N_MASTERS*AXI_ADDR_W-1:0] s_ar_araddr;
   logic [N_MASTERS*LEN_W-1:0]      s_ar_arlen;
   logic [N_MASTERS*SIZE_W-1:0]     s_ar_arsize;
   logic [N_MASTERS*BURST_W-1:0]    s_ar_arburst;
   logic [N_MASTERS-1:0]            s_ar_arvalid;
   logic [N_MASTERS-1:0]            s_ar_arready;
   logic [S_AXI_ID_W-1:0]           s_r_rid;
   logic [AXI_DATA_W-1:0]           s_r_rdata;
   logic [RESP_W-1:0]               s_r_rresp;
   logic                            s_r_rlast;
   logic [N_MASTERS-1:0]            s_r_rvalid;
   logic [N_MASTERS-1:0]            s_r_rready;
   logic [M_AXI_ID_W-1:0]           m_ar_arid;
   logic [AXI_ADDR_W-1:0]           m_ar_araddr;
   logic [LEN_W-1:0]                m_ar_arlen;
   logic [SIZE_W-1:0]               m_ar_arsize;
   logic [BURST_W-1:0]              m_ar_arburst;
   logic                            m_ar_arvalid;
   logic                            m_ar_arready;
   logic [M_AXI_ID_W-1:0]           m_r_rid;
   logic [AXI_DATA_W-1:0]           m_r_rdata;
   logic [RESP_W-1:0]               m_r_rresp;
   logic                            m_r_rlast;
   logic                            m_r_rvalid;
   logic                            m_r_rready;

   // master: the arbiter, which masters the memory port; slave: requesters plus memory
   modport master (
      input  s_ar_arid, s_ar_araddr, s_ar_arlen, s_ar_arsize, s_ar_arburst, s_ar_arvalid,
      output s_ar_arready,
      output s_r_rid, s_r_rdata, s_r_rresp, s_r_rlast, s_r_rvalid,
      input  s_r_rready,
      output m_ar_arid, m_ar_araddr, m_ar_arlen, m_ar_arsize, m_ar_arburst, m_ar_arvalid,
      input  m_ar_arready,
      input  m_r_rid, m_r_rdata, m_r_rresp, m_r_rlast, m_r_rvalid,
      output m_r_rready
   );

   modport slave (
      output s_ar_arid, s_ar_araddr, s_ar_arlen, s_ar_arsize, s_ar_arburst, s_ar_arvalid,
      input  s_ar_arready,
      input  s_r_rid, s_r_rdata, s_r_rresp, s_r_rlast, s_r_rvalid,
      output s_r_rready,
      input  m_ar_arid, m_ar_araddr, m_ar_arlen, m_ar_arsize, m_ar_arburst, m_ar_arvalid,
      output m_ar_arready,
      output m_r_rid, m_r_rdata, m_r_rresp, m_r_rlast, m_r_rvalid,
      input  m_r_rready
   );
endinterface

// File: rtl/zstd_rr_pick.sv
// rtl/zstd_rr_pick.sv - combinational round-robin picker: first request after the last grant
module zstd_rr_pick #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last,
   output logic             gnt_valid,
   output logic [IDX_W-1:0] gnt_idx
);
   // Walk distances from far to near so the nearest requester after last wins.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      for (int k = N; k >= 1; k--) begin
         for (int j = 0; j < N; j++) begin
            if (req[j] && (j == (int'(last) + k) % N)) begin
               gnt_valid = 1'b1;
               gnt_idx   = IDX_W'(j);
            end
         end
      end
   end
endmodule

// File: rtl/zstd_axi_rd_arbiter.sv
// rtl/zstd_axi_rd_arbiter.sv - round-robin AXI4 read-port arbiter with ID-based R routing
// ZSTD_AXI_RD_ARB_PERF_EN adds perf_grant_cnt, saturating per-master AR grant counters.
module zstd_axi_rd_arbiter
   import zstd_axi_arb_pkg::*;
#(
   parameter int N_MASTERS       = 2,
   parameter int AXI_DATA_W      = 32,
   parameter int AXI_ADDR_W      = 32,
   parameter int S_AXI_ID_W      = 4,
   parameter int IDX_W           = 1,
   parameter int M_AXI_ID_W      = 6,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   zstd_axi_rd_arbiter_if.master bus,
   output logic                 err_bad_rid
`ifdef ZSTD_AXI_RD_ARB_PERF_EN
   ,
   output logic [N_MASTERS*32-1:0] perf_grant_cnt
`endif
);
   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   if (IDX_W < clog2(N_MASTERS) || M_AXI_ID_W < S_AXI_ID_W + IDX_W) begin : g_bad_params
      $error("zstd_axi_rd_arbiter: IDX_W or M_AXI_ID_W too narrow");
   end

   logic [CNT_W-1:0]      outstanding [N_MASTERS];
   logic [N_MASTERS-1:0]  eligible, inc, dec, dec_eff;
   logic [IDX_W-1:0]      rr_ptr, pick_idx, r_idx;
   logic                  pick_valid, slot_free, grant;
   logic                  r_in_range, r_last_hs, r_bad_beat, underflow;
   logic [S_AXI_ID_W-1:0] sel_arid;
   logic [AXI_ADDR_W-1:0] sel_araddr;
   logic [LEN_W-1:0]      sel_arlen;
   logic [SIZE_W-1:0]     sel_arsize;
   logic [BURST_W-1:0]    sel_arburst;

   always_comb begin
      for (int i = 0; i < N_MASTERS; i++) begin
         eligible[i] = bus.s_ar_arvalid[i] && (outstanding[i] < MAX_CNT);
      end
   end

   zstd_rr_pick #(.N(N_MASTERS), .IDX_W(IDX_W)) u_pick (
      .req       (eligible),
      .last      (rr_ptr),
      .gnt_valid (pick_valid),
      .gnt_idx   (pick_idx)
   );

   // No handshake is offered while reset is held, so nothing is accepted and then forgotten.
   assign slot_free        = !bus.m_ar_arvalid || bus.m_ar_arready;
   assign grant            = !rst && slot_free && pick_valid;
   assign bus.s_ar_arready = grant ? (N_MASTERS'(1) << pick_idx) : '0;

   always_comb begin
      sel_arid    = '0;
      sel_araddr  = '0;
      sel_arlen   = '0;
      sel_arsize  = '0;
      sel_arburst = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (pick_idx == IDX_W'(i)) begin
            sel_arid    = bus.s_ar_arid[i*S_AXI_ID_W +: S_AXI_ID_W];
            sel_araddr  = bus.s_ar_araddr[i*AXI_ADDR_W +: AXI_ADDR_W];
            sel_arlen   = bus.s_ar_arlen[i*LEN_W +: LEN_W];
            sel_arsize  = bus.s_ar_arsize[i*SIZE_W +: SIZE_W];
            sel_arburst = bus.s_ar_arburst[i*BURST_W +: BURST_W];
         end
      end
   end

   assign r_idx         = bus.m_r_rid[S_AXI_ID_W +: IDX_W];
   assign r_in_range    = int'(r_idx) < N_MASTERS;
   assign bus.s_r_rid   = bus.m_r_rid[S_AXI_ID_W-1:0];
   assign bus.s_r_rdata = bus.m_r_rdata;
   assign bus.s_r_rresp = bus.m_r_rresp;
   assign bus.s_r_rlast = bus.m_r_rlast;

   // Beats for a nonexistent master are sunk so the memory side never stalls on them.
   always_comb begin
      bus.s_r_rvalid = '0;
      bus.m_r_rready = 1'b1;
      if (r_in_range) begin
         bus.s_r_rvalid = N_MASTERS'(bus.m_r_rvalid) << r_idx;
         for (int i = 0; i < N_MASTERS; i++) begin
            if (r_idx == IDX_W'(i)) bus.m_r_rready = bus.s_r_rready[i];
         end
      end
   end

   assign r_last_hs  = bus.m_r_rvalid && bus.m_r_rready && bus.m_r_rlast && r_in_range;
   assign r_bad_beat = bus.m_r_rvalid && !r_in_range;

   always_comb begin
      underflow = 1'b0;
      for (int i = 0; i < N_MASTERS; i++) begin
         inc[i]     = grant && (pick_idx == IDX_W'(i));
         dec[i]     = r_last_hs && (r_idx == IDX_W'(i));
         dec_eff[i] = dec[i] && (outstanding[i] != '0);
         if (dec[i] && (outstanding[i] == '0)) underflow = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.m_ar_arid    <= '0;
         bus.m_ar_araddr  <= '0;
         bus.m_ar_arlen   <= '0;
         bus.m_ar_arsize  <= '0;
         bus.m_ar_arburst <= '0;
         bus.m_ar_arvalid <= 1'b0;
         rr_ptr           <= IDX_W'(N_MASTERS - 1);
         err_bad_rid      <= 1'b0;
         for (int i = 0; i < N_MASTERS; i++) outstanding[i] <= '0;
      end else begin
         if (grant) begin
            bus.m_ar_arid    <= M_AXI_ID_W'({pick_idx, sel_arid});
            bus.m_ar_araddr  <= sel_araddr;
            bus.m_ar_arlen   <= sel_arlen;
            bus.m_ar_arsize  <= sel_arsize;
            bus.m_ar_arburst <= sel_arburst;
            bus.m_ar_arvalid <= 1'b1;
            rr_ptr           <= pick_idx;
         end else if (bus.m_ar_arready) begin
            bus.m_ar_arvalid <= 1'b0;
         end
         for (int i = 0; i < N_MASTERS; i++) begin
            if (inc[i] && !dec_eff[i]) outstanding[i] <= outstanding[i] + 1'b1;
            else if (dec_eff[i] && !inc[i]) outstanding[i] <= outstanding[i] - 1'b1;
         end
         if (r_bad_beat || underflow) err_bad_rid <= 1'b1;
      end
   end

`ifdef ZSTD_AXI_RD_ARB_PERF_EN
   logic [31:0] grant_cnt [N_MASTERS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_MASTERS; i++) grant_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_MASTERS; i++) begin
            if (inc[i] && (grant_cnt[i] != 32'hFFFF_FFFF)) grant_cnt[i] <= grant_cnt[i] + 32'd1;
         end
      end
   end

   for (genvar g = 0; g < N_MASTERS; g++) begin : g_perf
      assign perf_grant_cnt[g*32 +: 32] = grant_cnt[g];
   end
`endif
endmodule

// File: tb/tb_zstd_axi_rd_arbiter.sv
// tb/tb_zstd_axi_rd_arbiter.sv - directed self-checking bench for zstd_axi_rd_arbiter
module tb_zstd_axi_rd_arbiter;
   localparam int N  = 2;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int SW = 4;
   localparam int IW = 2;
   localparam int MW = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic err_bad_rid;
`ifdef ZSTD_AXI_RD_ARB_PERF_EN
   logic [N*32-1:0] perf_grant_cnt;
`endif

   always #5 clk = ~clk;

   zstd_axi_rd_arbiter_if #(.N_MASTERS(N), .AXI_DATA_W(DW), .AXI_ADDR_W(AW),
                            .S_AXI_ID_W(SW), .M_AXI_ID_W(MW)) bus ();

   zstd_axi_rd_arbiter #(.N_MASTERS(N), .AXI_DATA_W(DW), .AXI_ADDR_W(AW), .S_AXI_ID_W(SW),
                         .IDX_W(IW), .M_AXI_ID_W(MW), .MAX_OUTSTANDING(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .err_bad_rid (err_bad_rid)
`ifdef ZSTD_AXI_RD_ARB_PERF_EN
      ,
      .perf_grant_cnt (perf_grant_cnt)
`endif
   );

   typedef struct {
      logic [5:0]  rid;
      logic        rvalid;
      logic [1:0]  rready;
      logic [31:0] rdata;
      logic [1:0]  exp_rvalid;
      logic        exp_rready;
   } r_vec_t;

   r_vec_t rtab [6];
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      bus.s_ar_arvalid = '0;
      bus.s_r_rready   = '0;
      bus.m_ar_arready = 1'b1;
      bus.m_r_rvalid   = 1'b0;
      bus.m_r_rlast    = 1'b0;
      bus.m_r_rid      = '0;
      bus.m_r_rdata    = '0;
      bus.m_r_rresp    = 3'b101;
   endtask

   task automatic set_ar(input int m, input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
      bus.s_ar_arid[m*SW +: SW]    = id;
      bus.s_ar_araddr[m*AW +: AW]  = addr;
      bus.s_ar_arlen[m*8 +: 8]     = len;
      bus.s_ar_arsize[m*3 +: 3]    = 3'd2;
      bus.s_ar_arburst[m*2 +: 2]   = 2'd1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      logic [1:0] exp_rdy [6];
      logic [5:0] exp_id [4];

      rtab[0] = '{6'h03, 1'b1, 2'b01, 32'hA0A0_0001, 2'b01, 1'b1};
      rtab[1] = '{6'h03, 1'b1, 2'b10, 32'hA0A0_0002, 2'b01, 1'b0};
      rtab[2] = '{6'h15, 1'b1, 2'b10, 32'hB0B0_0003, 2'b10, 1'b1};
      rtab[3] = '{6'h1F, 1'b1, 2'b01, 32'hB0B0_0004, 2'b10, 1'b0};
      rtab[4] = '{6'h1A, 1'b0, 2'b11, 32'hC0C0_0005, 2'b00, 1'b1};
      rtab[5] = '{6'h0C, 1'b0, 2'b00, 32'hC0C0_0006, 2'b00, 1'b0};

      idle();
      set_ar(0, 4'h0, 32'h0, 8'h0);
      set_ar(1, 4'h0, 32'h0, 8'h0);
      bus.s_ar_arvalid = 2'b01;
      rst = 1'b1;
      repeat (3) step();
      settle();
      chk("rst_m_arvalid", bus.m_ar_arvalid, 0);
      chk("rst_m_arid", bus.m_ar_arid, 0);
      chk("rst_m_araddr", bus.m_ar_araddr, 0);
      chk("rst_s_arready", bus.s_ar_arready, 0);
      chk("rst_err", err_bad_rid, 0);
      bus.s_ar_arvalid = '0;
      rst = 1'b0;
      step();

      // single burst from master 0
      set_ar(0, 4'h3, 32'h100, 8'd7);
      bus.s_ar_arvalid = 2'b01;
      settle();
      chk("s1_grant", bus.s_ar_arready, 2'b01);
      step();
      bus.s_ar_arvalid = '0;
      settle();
      chk("s1_arvalid", bus.m_ar_arvalid, 1);
      chk("s1_arid", bus.m_ar_arid, 6'h03);
      chk("s1_araddr", bus.m_ar_araddr, 32'h100);
      chk("s1_arlen", bus.m_ar_arlen, 7);
      chk("s1_arsize", bus.m_ar_arsize, 2);
      chk("s1_arburst", bus.m_ar_arburst, 1);
      step();
      chk("s1_arvalid_drop", bus.m_ar_arvalid, 0);
      bus.s_r_rready = 2'b01;
      for (int b = 0; b < 8; b++) begin
         bus.m_r_rid    = 6'h03;
         bus.m_r_rvalid = 1'b1;
         bus.m_r_rdata  = 32'hD000 + b;
         bus.m_r_rlast  = (b == 7);
         settle();
         chk("s1_r_rvalid", bus.s_r_rvalid, 2'b01);
         chk("s1_r_rready", bus.m_r_rready, 1);
         chk("s1_r_rdata", bus.s_r_rdata, 32'hD000 + b);
         if (b == 0) chk("s1_r_rresp", bus.s_r_rresp, 3'b101);
         step();
      end
      bus.m_r_rvalid = 1'b0;
      bus.m_r_rlast  = 1'b0;
      exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b01; exp_rdy[2] = 2'b00;
      bus.s_ar_arvalid = 2'b01;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("s1_refill", bus.s_ar_arready, exp_rdy[k]);
         step();
      end
      bus.s_ar_arvalid = '0;
      for (int b = 0; b < 2; b++) begin
         bus.m_r_rid = 6'h00; bus.m_r_rvalid = 1'b1; bus.m_r_rlast = 1'b1;
         step();
      end
      idle();
      step();

      // combinational R routing table
      for (int v = 0; v < 6; v++) begin
         bus.m_r_rid    = rtab[v].rid;
         bus.m_r_rvalid = rtab[v].rvalid;
         bus.s_r_rready = rtab[v].rready;
         bus.m_r_rdata  = rtab[v].rdata;
         bus.m_r_rlast  = 1'b0;
         settle();
         chk($sformatf("tab%0d_s_rvalid", v), bus.s_r_rvalid, rtab[v].exp_rvalid);
         chk($sformatf("tab%0d_m_rready", v), bus.m_r_rready, rtab[v].exp_rready);
         chk($sformatf("tab%0d_s_rid", v), bus.s_r_rid, rtab[v].rid[3:0]);
         chk($sformatf("tab%0d_s_rdata", v), bus.s_r_rdata, rtab[v].rdata);
         chk($sformatf("tab%0d_err", v), err_bad_rid, 0);
         step();
      end
      idle();

      // both masters continuously requesting: alternate until each hits the limit
      do_reset();
      set_ar(0, 4'h5, 32'h1000, 8'd0);
      set_ar(1, 4'hA, 32'h2000, 8'd0);
      exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b10; exp_rdy[2] = 2'b01;
      exp_rdy[3] = 2'b10; exp_rdy[4] = 2'b00;
      exp_id[0] = 6'h05; exp_id[1] = 6'h1A; exp_id[2] = 6'h05; exp_id[3] = 6'h1A;
      bus.s_ar_arvalid = 2'b11;
      for (int k = 0; k < 5; k++) begin
         settle();
         chk($sformatf("rr_grant%0d", k), bus.s_ar_arready, exp_rdy[k]);
         if (k > 0) begin
            chk($sformatf("rr_arid%0d", k - 1), bus.m_ar_arid, exp_id[k - 1]);
            chk($sformatf("rr_arvalid%0d", k - 1), bus.m_ar_arvalid, 1);
         end
         step();
      end
      settle();
      chk("rr_idle_arvalid", bus.m_ar_arvalid, 0);

      // reset with bursts in flight
      bus.m_r_rid = 6'h00; bus.m_r_rvalid = 1'b1; bus.s_r_rready = 2'b01;
      rst = 1'b1;
      step();
      settle();
      chk("mid_rst_arvalid", bus.m_ar_arvalid, 0);
      chk("mid_rst_arready", bus.s_ar_arready, 0);
      chk("mid_rst_err", err_bad_rid, 0);
      rst = 1'b0;
      bus.m_r_rvalid = 1'b0;
      bus.s_r_rready = '0;
      settle();
      chk("post_rst_first", bus.s_ar_arready, 2'b01);
      step();
      settle();
      chk("post_rst_second", bus.s_ar_arready, 2'b10);
      step();
      idle();
      step();

      // outstanding limit on master 1
      do_reset();
      set_ar(1, 4'h2, 32'h3000, 8'd3);
      exp_rdy[0] = 2'b10; exp_rdy[1] = 2'b10; exp_rdy[2] = 2'b00;
      exp_rdy[3] = 2'b00; exp_rdy[4] = 2'b00; exp_rdy[5] = 2'b00;
      bus.s_ar_arvalid = 2'b10;
      for (int k = 0; k < 6; k++) begin
         settle();
         chk($sformatf("lim%0d", k), bus.s_ar_arready, exp_rdy[k]);
         step();
      end
      bus.m_r_rid = 6'h12; bus.m_r_rvalid = 1'b1; bus.m_r_rlast = 1'b1; bus.s_r_rready = 2'b10;
      settle();
      chk("lim_rlast_same", bus.s_ar_arready, 2'b00);
      chk("lim_rlast_route", bus.s_r_rvalid, 2'b10);
      step();
      bus.m_r_rvalid = 1'b0; bus.m_r_rlast = 1'b0; bus.s_r_rready = '0;
      settle();
      chk("lim_release", bus.s_ar_arready, 2'b10);
      step();
      bus.s_ar_arvalid = '0;
      settle();
      chk("lim_arid", bus.m_ar_arid, 6'h12);
      step();

      // memory AR stall: registered fields must hold
      bus.m_ar_arready = 1'b0;
      set_ar(0, 4'h7, 32'h200, 8'd3);
      bus.s_ar_arvalid = 2'b01;
      settle();
      chk("stall_first_grant", bus.s_ar_arready, 2'b01);
      step();
      set_ar(0, 4'h7, 32'h300, 8'd3);
      for (int k = 0; k < 5; k++) begin
         settle();
         chk($sformatf("stall%0d_arready", k), bus.s_ar_arready, 2'b00);
         chk($sformatf("stall%0d_arvalid", k), bus.m_ar_arvalid, 1);
         chk($sformatf("stall%0d_araddr", k), bus.m_ar_araddr, 32'h200);
         chk($sformatf("stall%0d_arid", k), bus.m_ar_arid, 6'h07);
         step();
      end
      bus.m_ar_arready = 1'b1;
      settle();
      chk("stall_release_grant", bus.s_ar_arready, 2'b01);
      step();
      bus.s_ar_arvalid = '0;
      settle();
      chk("stall_next_araddr", bus.m_ar_araddr, 32'h300);
      chk("stall_next_arvalid", bus.m_ar_arvalid, 1);
      step();

      // R beat for a nonexistent master
      bus.m_r_rid = 6'h25; bus.m_r_rvalid = 1'b1; bus.m_r_rlast = 1'b0; bus.s_r_rready = '0;
      settle();
      chk("bad_rid_rready", bus.m_r_rready, 1);
      chk("bad_rid_rvalid", bus.s_r_rvalid, 2'b00);
      chk("bad_rid_err_before", err_bad_rid, 0);
      step();
      bus.m_r_rvalid = 1'b0;
      settle();
      chk("bad_rid_err_set", err_bad_rid, 1);
      repeat (3) step();
      chk("bad_rid_err_sticky", err_bad_rid, 1);
      do_reset();
      settle();
      chk("bad_rid_err_cleared", err_bad_rid, 0);

      // rlast with nothing outstanding
      bus.m_r_rid = 6'h01; bus.m_r_rvalid = 1'b1; bus.m_r_rlast = 1'b1; bus.s_r_rready = 2'b01;
      settle();
      step();
      idle();
      settle();
      chk("underflow_err", err_bad_rid, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
